// File: rtl/arb8_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arb8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10
  } arb_state_e;

  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/arb_burst_cnt.sv
// Burst beat counter: counts accepted beats, saturates at MAX_BURST, clears on grant exit.
import arb8_pkg::*;

module arb_burst_cnt #(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cntInc;

  // Limit is judged on the count including this cycle's beat.
  always_comb begin
    cntInc = cnt_q;
    if (inc_i && (cnt_q != MAX_C)) begin
      cntInc = cnt_q + CNT_W'(1);
    end
    limit_o = (cntInc == MAX_C);
    cnt_d   = clr_i ? '0 : cntInc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux8_2x1.sv
// 8-bit 2:1 mux: sel=1 passes in1, sel=0 passes in2.
module mux8_2x1 (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       sel,
  output logic [7:0] out
);

  assign out = sel ? in1 : in2;

endmodule

// File: rtl/arb8_2x1.sv
// Round-robin arbiter sharing one registered 8-bit output channel between two requesters.
// Optional ARB_STATS_EN adds saturating per-requester ack counters beats1/beats2.
import arb8_pkg::*;

module arb8_2x1 #(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic              req2,
  input  logic [DATA_W-1:0] data2,
  output logic              gnt1,
  output logic              gnt2,
  output logic              ack1,
  output logic              ack2,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]        beats1,
  output logic [7:0]        beats2
`endif
);

  arb_state_e        state_q, state_d;
  logic              prio1_q, prio1_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [DATA_W-1:0] muxOut;
  logic              canLoad;
  logic              ackAny;
  logic              grantExit;
  logic              limitHit;

  mux8_2x1 uMux (
    .in1 (data1),
    .in2 (data2),
    .sel (sel),
    .out (muxOut)
  );

  arb_burst_cnt #(.MAX_BURST(MAX_BURST)) uBurst (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ackAny),
    .clr_i   (grantExit),
    .limit_o (limitHit)
  );

  // Grant decode, acks and next-state; a grant hands over directly with no IDLE bubble.
  always_comb begin
    canLoad = !outValid_q || out_ready;
    gnt1    = (state_q == GNT1);
    gnt2    = (state_q == GNT2);
    sel     = gnt1;
    ack1    = gnt1 && req1 && canLoad;
    ack2    = gnt2 && req2 && canLoad;
    ackAny  = ack1 || ack2;
    state_d = state_q;
    prio1_d = prio1_q;
    case (state_q)
      IDLE: begin
        if (req1 && (!req2 || prio1_q)) begin
          state_d = GNT1;
        end else if (req2) begin
          state_d = GNT2;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = req2 ? GNT2 : IDLE;
        end else if (limitHit && req2) begin
          state_d = GNT2;
        end
      end
      GNT2: begin
        if (!req2) begin
          state_d = req1 ? GNT1 : IDLE;
        end else if (limitHit && req1) begin
          state_d = GNT1;
        end
      end
      default: state_d = IDLE;
    endcase
    grantExit = (state_q != IDLE) && (state_d != state_q);
    if (grantExit) begin
      prio1_d = (state_q == GNT2);
    end
  end

  // An ack in the same cycle as consumption keeps the channel full.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (ackAny) begin
      outValid_d = 1'b1;
      outData_d  = muxOut;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio1_q    <= 1'b1;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      prio1_q    <= prio1_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;

`ifdef ARB_STATS_EN
  logic [7:0] beats1_q, beats2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats1_q <= 8'h00;
      beats2_q <= 8'h00;
    end else begin
      if (ack1 && (beats1_q != 8'hFF)) beats1_q <= beats1_q + 8'h01;
      if (ack2 && (beats2_q != 8'hFF)) beats2_q <= beats2_q + 8'h01;
    end
  end

  assign beats1 = beats1_q;
  assign beats2 = beats2_q;
`endif

endmodule

// File: tb/tb_arb8_2x1.sv
// Self-checking bench for arb8_2x1: vector table for grants/acks plus a data scoreboard.
module tb_arb8_2x1;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req1      = 1'b0;
  logic       req2      = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] data1     = 8'h00;
  logic [7:0] data2     = 8'h00;
  logic       gnt1, gnt2, ack1, ack2, sel, out_valid;
  logic [7:0] out_data;
`ifdef ARB_STATS_EN
  logic [7:0] beats1, beats2;
`endif

  arb8_2x1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req1      (req1),
    .data1     (data1),
    .req2      (req2),
    .data2     (data2),
    .gnt1      (gnt1),
    .gnt2      (gnt2),
    .ack1      (ack1),
    .ack2      (ack2),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ARB_STATS_EN
    ,
    .beats1    (beats1),
    .beats2    (beats2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rstN;
    bit         r1;
    logic [7:0] d1;
    bit         r2;
    logic [7:0] d2;
    bit         rdy;
    bit         g1;
    bit         g2;
    bit         a1;
    bit         a2;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sbQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         tally1     = 0;
  int         tally2     = 0;

  task automatic addVec(input bit rstN, input bit r1, input logic [7:0] d1,
                        input bit r2, input logic [7:0] d2, input bit rdy,
                        input bit g1, input bit g2, input bit a1, input bit a2);
    vec_t v;
    v.rstN = rstN; v.r1 = r1; v.d1 = d1; v.r2 = r2; v.d2 = d2; v.rdy = rdy;
    v.g1 = g1; v.g2 = g2; v.a1 = a1; v.a2 = a2;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input bit rstN, input bit r1, input logic [7:0] d1,
                               input bit r2, input logic [7:0] d2, input bit rdy);
    @(negedge clk);
    rst_n     = rstN;
    req1      = r1;
    data1     = d1;
    req2      = r2;
    data2     = d2;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pop/compare the beat being offered, then push whatever this cycle captures.
  task automatic scoreboardStep(input int idx, input bit rdy, input bit a1, input bit a2,
                                input logic [7:0] d1, input logic [7:0] d2);
    checkOutput($sformatf("v%0d_out_valid", idx), {7'b0, out_valid}, {7'b0, sbQ.size() != 0});
    if (sbQ.size() != 0) begin
      checkOutput($sformatf("v%0d_out_data", idx), out_data, sbQ[0]);
      if (rdy) void'(sbQ.pop_front());
    end
    if (a1) sbQ.push_back(d1);
    if (a2) sbQ.push_back(d2);
  endtask

  initial begin
    // Reset with both requesting, then release: GNT1 wins first.
    addVec(0, 1, 8'h00, 1, 8'h00, 1,  0, 0, 0, 0);
    addVec(1, 1, 8'h00, 1, 8'h00, 1,  0, 0, 0, 0);
    // Both requesting continuously: 4 beats to 1, 4 to 2, 4 to 1.
    for (int i = 0; i < 12; i++) begin
      addVec(1, 1, 8'(8'h10 + i), 1, 8'(8'h20 + i), 1,
             (i / 4) != 1, (i / 4) == 1, (i / 4) != 1, (i / 4) == 1);
    end
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0);
    // Single requester 2.
    addVec(1, 0, 8'h00, 1, 8'hA5, 1,  0, 0, 0, 0);
    addVec(1, 0, 8'h00, 1, 8'hA5, 1,  0, 1, 0, 1);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0);
    // Backpressure during GNT1.
    addVec(1, 1, 8'h31, 0, 8'h00, 1,  0, 0, 0, 0);
    addVec(1, 1, 8'h31, 0, 8'h00, 1,  1, 0, 1, 0);
    addVec(1, 1, 8'h32, 0, 8'h00, 0,  1, 0, 0, 0);
    addVec(1, 1, 8'h32, 0, 8'h00, 0,  1, 0, 0, 0);
    addVec(1, 1, 8'h32, 0, 8'h00, 0,  1, 0, 0, 0);
    addVec(1, 1, 8'h32, 0, 8'h00, 1,  1, 0, 1, 0);
    // Early release after 2 beats; GNT2 must then get a full burst of 4.
    addVec(1, 0, 8'h00, 1, 8'h41, 1,  1, 0, 0, 0);
    addVec(1, 1, 8'h34, 1, 8'h41, 1,  0, 1, 0, 1);
    addVec(1, 1, 8'h34, 1, 8'h42, 1,  0, 1, 0, 1);
    addVec(1, 1, 8'h34, 1, 8'h43, 1,  0, 1, 0, 1);
    addVec(1, 1, 8'h34, 1, 8'h44, 1,  0, 1, 0, 1);
    addVec(1, 1, 8'h34, 1, 8'h45, 1,  1, 0, 1, 0);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 0);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].r1, vecs[i].d1, vecs[i].r2, vecs[i].d2, vecs[i].rdy);
      checkOutput($sformatf("v%0d_gnt1", i), {7'b0, gnt1}, {7'b0, vecs[i].g1});
      checkOutput($sformatf("v%0d_gnt2", i), {7'b0, gnt2}, {7'b0, vecs[i].g2});
      checkOutput($sformatf("v%0d_ack1", i), {7'b0, ack1}, {7'b0, vecs[i].a1});
      checkOutput($sformatf("v%0d_ack2", i), {7'b0, ack2}, {7'b0, vecs[i].a2});
      checkOutput($sformatf("v%0d_sel", i),  {7'b0, sel},  {7'b0, vecs[i].g1});
      if (!vecs[i].rstN) begin
        sbQ.delete();
        checkOutput($sformatf("v%0d_rst_out_valid", i), {7'b0, out_valid}, 8'h00);
        checkOutput($sformatf("v%0d_rst_out_data", i), out_data, 8'h00);
      end else begin
        scoreboardStep(i, vecs[i].rdy, vecs[i].a1, vecs[i].a2, vecs[i].d1, vecs[i].d2);
      end
      if (vecs[i].a1) tally1++;
      if (vecs[i].a2) tally2++;
    end

`ifdef ARB_STATS_EN
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
    checkOutput("beats1_total", beats1, 8'(tally1));
    checkOutput("beats2_total", beats2, 8'(tally2));
`endif

    // Mid-burst reset during GNT2 with a beat held in the output register.
    applyStimulus(1, 0, 8'h00, 1, 8'h5A, 1);
    checkOutput("mr_idle_gnt2", {7'b0, gnt2}, 8'h00);
    applyStimulus(1, 0, 8'h00, 1, 8'h5A, 1);
    checkOutput("mr_gnt2", {7'b0, gnt2}, 8'h01);
    checkOutput("mr_ack2", {7'b0, ack2}, 8'h01);
    checkOutput("mr_sel",  {7'b0, sel},  8'h00);
    applyStimulus(1, 0, 8'h00, 1, 8'h5B, 0);
    checkOutput("mr_stall_ack2", {7'b0, ack2}, 8'h00);
    checkOutput("mr_held_valid", {7'b0, out_valid}, 8'h01);
    checkOutput("mr_held_data", out_data, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_async_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("mr_async_data", out_data, 8'h00);
    checkOutput("mr_async_gnt2", {7'b0, gnt2}, 8'h00);
    checkOutput("mr_async_ack2", {7'b0, ack2}, 8'h00);
`ifdef ARB_STATS_EN
    checkOutput("mr_beats1", beats1, 8'h00);
    checkOutput("mr_beats2", beats2, 8'h00);
`endif
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
    checkOutput("mr_after_gnt1", {7'b0, gnt1}, 8'h00);
    checkOutput("mr_after_gnt2", {7'b0, gnt2}, 8'h00);
    // Pointer is back on requester 1 after reset.
    applyStimulus(1, 1, 8'h77, 1, 8'h88, 1);
    applyStimulus(1, 1, 8'h77, 1, 8'h88, 1);
    checkOutput("mr_restart_gnt1", {7'b0, gnt1}, 8'h01);
    checkOutput("mr_restart_ack1", {7'b0, ack1}, 8'h01);
    applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
    checkOutput("mr_restart_data", out_data, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arb8_2x1.md
Name: arb8_2x1

Overview:
- Round-robin arbiter sharing one 8-bit registered output channel between two requesters.
- Drives the select of the existing 2:1 8-bit mux (mux8_2x1, sel=1 passes in1, sel=0 passes in2).
- Captures the mux output into an output register with a valid/ready handshake toward the consumer.
- A burst limit prevents one requester from starving the other.

Parameters:
- MAX_BURST, 4: max consecutive accepted beats per grant while the other requester is waiting; legal range 1..15.
- DATA_W, 8: data width; only 8 is supported by the mux datapath.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req1  input  1  requester 1 has a beat on data1.
- data1  input  8  requester 1 data; held stable while req1=1 and ack1=0.
- req2  input  1  requester 2 has a beat on data2.
- data2  input  8  requester 2 data; same stability rule.
- gnt1  output  1  requester 1 owns the channel (state GNT1).
- gnt2  output  1  requester 2 owns the channel (state GNT2).
- ack1  output  1  data1 captured this cycle (combinational).
- ack2  output  1  data2 captured this cycle (combinational).
- sel  output  1  mux select: 1 in GNT1, 0 otherwise.
- out_data  output  8  registered output beat.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  consumer accepts out_data when out_valid=1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, out_valid=0, out_data=8'h00, burst count=0.
  - Priority pointer favours requester 1.
  - gnt1, gnt2, ack1, ack2 and sel are all 0.
- Reset asserted mid-burst aborts immediately. The beat held in out_data is lost and no ack is issued that cycle.
- can_load = !out_valid || out_ready.
- ackx = gntx && reqx && can_load. On ackx the next edge:
  - loads out_data from the mux output and sets out_valid=1;
  - increments the burst count.
- A beat is captured one cycle after it is presented with req and gnt active (out_data/out_valid registered, latency 1).
- If out_valid && out_ready && no ack, out_valid clears next edge. An ack in the same cycle keeps out_valid=1 (back-to-back throughput of 1 beat/cycle).
- IDLE:
  - Neither req: stay in IDLE.
  - Only req1: go to GNT1.
  - Only req2: go to GNT2.
  - Both: go to the requester favoured by the pointer.
  - A grant starts one cycle after the request; IDLE never acks.
- GNTx, evaluated at each edge:
  - reqx=0 and the other req=1: switch to the other grant.
  - reqx=0 and the other req=0: go to IDLE.
  - Count after this cycle's ack equals MAX_BURST and the other req=1: switch to the other grant.
  - Otherwise stay.
- Switching to the other grant goes directly, with no IDLE bubble. Every grant exit clears the count and points priority to the other requester.
- If the other requester is not waiting, the count saturates at MAX_BURST and the grant is kept.
- A grant is held while out_ready=0 (stall); the count does not advance without an ack.
- Count width: 4 bits.

Optional Feature:
- ARB_STATS_EN defined: adds output ports beats1 [7:0] and beats2 [7:0].
  - Each counts acks of its requester, saturating at 8'hFF; reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package arb8_pkg holds:
  - a state typedef (IDLE=2'b00, GNT1=2'b01, GNT2=2'b10);
  - the MAX_BURST default constant;
  - the count width constant.
- Datapath instantiates the existing mux8_2x1 with in1=data1, in2=data2, sel=sel.
- One natural sub-module: arb_burst_cnt (count, clear, saturate, limit-reached flag).

Test Plan:
- Reset: rst_n=0 with req1=req2=1 -> gnt1=gnt2=ack1=ack2=out_valid=0, out_data=8'h00; release -> gnt1=1 on the next cycle.
- Single requester: req2=1, data2=8'hA5, out_ready=1 -> gnt2 after 1 cycle, ack2 on that cycle, out_data=8'hA5 with out_valid=1 one cycle later, sel=0.
- Burst fairness: both requesting continuously, out_ready=1, MAX_BURST=4 -> exactly 4 acks to 1, then 4 to 2, alternating with no idle cycle between grants.
- Backpressure: GNT1, out_valid=1, out_ready=0 for 3 cycles -> ack1=0 and out_data stable; out_ready=1 -> ack1 that cycle, throughput resumes at 1/cycle.
- Early release: GNT1 after 2 beats, req1 drops while req2=1 -> GNT2 next cycle and the count is cleared.
- Mid-burst reset: rst_n pulsed low during GNT2 with out_valid=1 -> out_valid=0 immediately (asynchronous), state IDLE; with ARB_STATS_EN, beats1=beats2=0.
